// File: rtl/pc_bus_pkg.sv
// Shared 8088 bus definitions: status encodings and the wait-state generator
// state type.
package pc_bus_pkg;

  // 8088 S2..S0 status codes (active-low status pins, sampled as-is)
  localparam logic [2:0] ST_INTA    = 3'b000;
  localparam logic [2:0] ST_IOR     = 3'b001;
  localparam logic [2:0] ST_IOW     = 3'b010;
  localparam logic [2:0] ST_HALT    = 3'b011;
  localparam logic [2:0] ST_CODE    = 3'b100;
  localparam logic [2:0] ST_MEMR    = 3'b101;
  localparam logic [2:0] ST_MEMW    = 3'b110;
  localparam logic [2:0] ST_PASSIVE = 3'b111;

  typedef enum logic [2:0] {
    WS_IDLE,
    WS_IO_WAIT,
    WS_CH_WAIT,
    WS_DMA_ARM,
    WS_DMA_SYNC,
    WS_DMA_ACTIVE,
    WS_DMA_RELEASE
  } ws_state_t;

  // True for the two status codes that address I/O space
  function automatic logic is_io_code(input logic [2:0] s);
    return (s == ST_IOR) || (s == ST_IOW);
  endfunction

endpackage

// File: rtl/wait_state_gen_status_decode.sv
// Bus status decoder: spots the passive-to-active transition that marks the
// start of every 8088 bus cycle and classifies the cycle.
module status_decode
  import pc_bus_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] s_n,
  output logic       cycle_start,
  output logic       is_io,
  output logic       is_passive
);

  logic [2:0] s_q;

  // Keep last clock's status so a 111 -> non-111 change is seen exactly once
  always_ff @(posedge clk) begin
    if (!reset) s_q <= ST_PASSIVE;
    else        s_q <= s_n;
  end

  assign is_passive  = (s_n == ST_PASSIVE);
  assign cycle_start = (s_q == ST_PASSIVE) && !is_passive;
  assign is_io       = is_io_code(s_n);

endmodule

// File: rtl/wait_state_gen.sv
// Ready / wait-state generator feeding rdy1 and aen1 of the 8284A. Inserts
// fixed I/O waits, stretches cycles for slow expansion cards (with a
// timeout), and stalls the CPU while the 8237 owns the bus.
module wait_state_gen
  import pc_bus_pkg::*;
#(
  parameter int unsigned IO_WAITS   = 1,
  parameter int unsigned CH_TIMEOUT = 255,
  parameter int unsigned DMA_SYNC   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] s_n,
  input  logic       io_ch_rdy,
  input  logic       lock_n,
  input  logic       dma_req,
  output logic       rdy1,
  output logic       aen1,
  output logic       dma_ack,
  output logic       ch_timeout
);

  localparam bit         IO_WAIT_EN = (IO_WAITS != 0);
  localparam logic [3:0] IO_LOAD    = 4'(IO_WAITS);
  localparam logic [3:0] SYNC_LOAD  = 4'(DMA_SYNC);
  localparam logic [7:0] TMO_LAST   = 8'(CH_TIMEOUT - 1);

  ws_state_t  state;
  logic [3:0] cnt;
  logic [7:0] tcnt;
  logic       cycle_start;
  logic       is_io;
  logic       is_passive;

  status_decode u_decode (
    .clk         (clk),
    .reset       (reset),
    .s_n         (s_n),
    .cycle_start (cycle_start),
    .is_io       (is_io),
    .is_passive  (is_passive)
  );

  // Main controller: state, counters and all registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= WS_IDLE;
      cnt        <= 4'd0;
      tcnt       <= 8'd0;
      rdy1       <= 1'b1;
      aen1       <= 1'b0;
      dma_ack    <= 1'b0;
      ch_timeout <= 1'b0;
    end else begin
      ch_timeout <= 1'b0;
      case (state)
        WS_IDLE: begin
          rdy1    <= 1'b1;
          aen1    <= 1'b0;
          dma_ack <= 1'b0;
          if (dma_req && lock_n && is_passive) begin
            state <= WS_DMA_ARM;
          end else if (cycle_start && is_io && IO_WAIT_EN) begin
            state <= WS_IO_WAIT;
            cnt   <= IO_LOAD;
            rdy1  <= 1'b0;
          end else if (cycle_start && !io_ch_rdy) begin
            state <= WS_CH_WAIT;
            tcnt  <= 8'd0;
            rdy1  <= 1'b0;
          end
        end

        WS_IO_WAIT: begin
          if (cnt == 4'd1) begin
            if (!io_ch_rdy) begin
              state <= WS_CH_WAIT;
              tcnt  <= 8'd0;
            end else begin
              state <= WS_IDLE;
              rdy1  <= 1'b1;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        WS_CH_WAIT: begin
          if (io_ch_rdy) begin
            state <= WS_IDLE;
            rdy1  <= 1'b1;
          end else if (tcnt == TMO_LAST) begin
            state      <= WS_IDLE;
            rdy1       <= 1'b1;
            ch_timeout <= 1'b1;
          end else if (tcnt != 8'hFF) begin
            tcnt <= tcnt + 8'd1;
          end
        end

        WS_DMA_ARM: begin
          if (!dma_req) begin
            state <= WS_IDLE;
          end else if (cycle_start) begin
            state <= WS_DMA_SYNC;
            cnt   <= SYNC_LOAD;
            rdy1  <= 1'b0;
            aen1  <= 1'b1;
          end
        end

        WS_DMA_SYNC: begin
          if (cnt == 4'd1) begin
            state   <= WS_DMA_ACTIVE;
            dma_ack <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        WS_DMA_ACTIVE: begin
          if (!dma_req) begin
            state   <= WS_DMA_RELEASE;
            dma_ack <= 1'b0;
          end
        end

        WS_DMA_RELEASE: begin
          state <= WS_IDLE;
          aen1  <= 1'b0;
          rdy1  <= 1'b1;
        end

        default: begin
          state   <= WS_IDLE;
          rdy1    <= 1'b1;
          aen1    <= 1'b0;
          dma_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wait_state_gen.sv
// Scoreboard bench for wait_state_gen: each stimulus step queues the output
// vector expected after its clock edge, and a monitor compares it one half
// clock later.
module tb_wait_state_gen;
  import pc_bus_pkg::*;

  // Expected output vector order: {rdy1, aen1, dma_ack, ch_timeout}
  localparam logic [3:0] O_IDLE = 4'b1000;
  localparam logic [3:0] O_WAIT = 4'b0000;
  localparam logic [3:0] O_DMA  = 4'b0100;
  localparam logic [3:0] O_ACK  = 4'b0110;
  localparam logic [3:0] O_TMO  = 4'b1001;

  typedef struct {
    logic [3:0] exp;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  logic       clk       = 1'b0;
  logic       reset     = 1'b0;
  logic [2:0] s_n       = 3'b111;
  logic       io_ch_rdy = 1'b1;
  logic       lock_n    = 1'b1;
  logic       dma_req   = 1'b0;
  logic       rdy1;
  logic       aen1;
  logic       dma_ack;
  logic       ch_timeout;

  wait_state_gen #(
    .IO_WAITS   (1),
    .CH_TIMEOUT (255),
    .DMA_SYNC   (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s_n        (s_n),
    .io_ch_rdy  (io_ch_rdy),
    .lock_n     (lock_n),
    .dma_req    (dma_req),
    .rdy1       (rdy1),
    .aen1       (aen1),
    .dma_ack    (dma_ack),
    .ch_timeout (ch_timeout)
  );

  // Free-running CPU clock
  always #5 clk = ~clk;

  // Drive one clock of inputs and queue the outputs expected after that edge
  task automatic applyStimulus(input logic [2:0] s, input logic ch, input logic lk,
                               input logic rq, input logic rst,
                               input logic [3:0] exp, input string name);
    @(negedge clk);
    s_n       = s;
    io_ch_rdy = ch;
    lock_n    = lk;
    dma_req   = rq;
    reset     = rst;
    @(posedge clk);
    #1;
    sb.push_back('{exp, name});
  endtask

  // Compare live DUT outputs against one scoreboard entry
  task automatic checkOutput(input exp_t e);
    logic [3:0] act;
    act = {rdy1, aen1, dma_ack, ch_timeout};
    checks++;
    if (act !== e.exp) begin
      failures++;
      $display("[TB] FAIL %s: rdy1/aen1/dma_ack/ch_timeout got %b expected %b",
               e.name, act, e.exp);
    end
  endtask

  // Monitor: pops an expectation each negedge once the DUT has produced it
  always @(negedge clk) begin
    if (sb.size() > 0) checkOutput(sb.pop_front());
  end

  // Hard stop in case something stalls the stimulus
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus with hand-computed expectations
  initial begin
    // Reset
    for (int i = 0; i < 3; i++) applyStimulus(3'b111, 1, 1, 0, 0, O_IDLE, "reset");
    for (int i = 0; i < 2; i++) applyStimulus(3'b111, 1, 1, 0, 1, O_IDLE, "idle");

    // I/O read: one forced wait
    applyStimulus(3'b001, 1, 1, 0, 1, O_WAIT, "ior_wait");
    applyStimulus(3'b001, 1, 1, 0, 1, O_IDLE, "ior_release");
    applyStimulus(3'b001, 1, 1, 0, 1, O_IDLE, "ior_hold");
    applyStimulus(3'b111, 1, 1, 0, 1, O_IDLE, "ior_end");

    // Memory read: no waits
    for (int i = 0; i < 3; i++) applyStimulus(3'b101, 1, 1, 0, 1, O_IDLE, "memr");
    applyStimulus(3'b111, 1, 1, 0, 1, O_IDLE, "memr_end");

    // I/O write with io_ch_rdy low for six clocks
    for (int i = 0; i < 6; i++) applyStimulus(3'b010, 0, 1, 0, 1, O_WAIT, "iow_chwait");
    applyStimulus(3'b010, 1, 1, 0, 1, O_IDLE, "iow_release");
    applyStimulus(3'b111, 1, 1, 0, 1, O_IDLE, "iow_end");

    // io_ch_rdy stuck low on a memory cycle: timeout 255 clocks into CH_WAIT
    applyStimulus(3'b101, 0, 1, 0, 1, O_WAIT, "ch_enter");
    for (int i = 0; i < 254; i++) applyStimulus(3'b101, 0, 1, 0, 1, O_WAIT, "ch_stuck");
    applyStimulus(3'b101, 0, 1, 0, 1, O_TMO, "ch_timeout");
    applyStimulus(3'b101, 0, 1, 0, 1, O_IDLE, "ch_after");
    applyStimulus(3'b111, 1, 1, 0, 1, O_IDLE, "ch_end");

    // Interrupt acknowledge and halt: no waits
    for (int i = 0; i < 2; i++) applyStimulus(3'b000, 1, 1, 0, 1, O_IDLE, "inta");
    applyStimulus(3'b111, 1, 1, 0, 1, O_IDLE, "inta_end");
    for (int i = 0; i < 2; i++) applyStimulus(3'b011, 1, 1, 0, 1, O_IDLE, "halt");
    applyStimulus(3'b111, 1, 1, 0, 1, O_IDLE, "halt_end");

    // DMA hand-off
    applyStimulus(3'b111, 1, 1, 1, 1, O_IDLE, "dma_arm");
    applyStimulus(3'b111, 1, 1, 1, 1, O_IDLE, "dma_armed");
    applyStimulus(3'b101, 1, 1, 1, 1, O_DMA,  "dma_stall");
    applyStimulus(3'b101, 1, 1, 1, 1, O_DMA,  "dma_sync");
    applyStimulus(3'b101, 1, 1, 1, 1, O_ACK,  "dma_ack");
    for (int i = 0; i < 2; i++) applyStimulus(3'b111, 1, 1, 1, 1, O_ACK, "dma_active");
    applyStimulus(3'b111, 1, 1, 0, 1, O_DMA,  "dma_release");
    applyStimulus(3'b111, 1, 1, 0, 1, O_IDLE, "dma_done");
    applyStimulus(3'b111, 1, 1, 0, 1, O_IDLE, "dma_idle");

    // Armed DMA abandoned before any cycle start
    applyStimulus(3'b111, 1, 1, 1, 1, O_IDLE, "abort_arm");
    applyStimulus(3'b111, 1, 1, 0, 1, O_IDLE, "abort_drop");
    applyStimulus(3'b101, 1, 1, 1, 1, O_IDLE, "abort_cycle");
    applyStimulus(3'b111, 1, 1, 0, 1, O_IDLE, "abort_end");

    // LOCK blocks arming; one passive clock with lock released arms it
    for (int i = 0; i < 3; i++) applyStimulus(3'b111, 1, 0, 1, 1, O_IDLE, "lock_block");
    for (int i = 0; i < 2; i++) applyStimulus(3'b101, 1, 0, 1, 1, O_IDLE, "lock_cycle");
    applyStimulus(3'b111, 1, 0, 1, 1, O_IDLE, "lock_passive");
    applyStimulus(3'b111, 1, 1, 1, 1, O_IDLE, "lock_release");
    applyStimulus(3'b111, 1, 0, 1, 1, O_IDLE, "lock_armed");
    applyStimulus(3'b101, 1, 0, 1, 1, O_DMA,  "lock_stall");
    applyStimulus(3'b101, 1, 0, 1, 1, O_DMA,  "lock_sync");
    applyStimulus(3'b101, 1, 0, 1, 1, O_ACK,  "lock_ack");
    applyStimulus(3'b111, 1, 0, 1, 1, O_ACK,  "lock_active");

    // Reset held three clocks while DMA is active
    for (int i = 0; i < 3; i++) applyStimulus(3'b111, 1, 1, 1, 0, O_IDLE, "rst_dma");
    for (int i = 0; i < 2; i++) applyStimulus(3'b111, 1, 1, 0, 1, O_IDLE, "rst_after");

    // Let the monitor drain the scoreboard
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wait_state_gen.md
Name: wait_state_gen

Overview:
- Ready/wait-state generator directly upstream of the intel8284a clock generator; drives its rdy1 and aen1 inputs.
- Decodes 8088 bus status, inserts fixed I/O wait states, and stretches cycles while an expansion card holds io_ch_rdy low.
- Arbitrates DMA bus hand-off to the 8237 by stalling the CPU.
- Runs in the CPU clock domain produced by the 8284A.

Parameters:
- IO_WAITS, 1, wait states forced on every I/O read/write cycle (0..15).
- CH_TIMEOUT, 255, max cycles io_ch_rdy may stay low before ready is forced (1..255).
- DMA_SYNC, 2, cycles between CPU stall and dma_ack assertion (1..15).

Ports:
- clk  input  1  CPU clock (8284A clk output).
- reset  input  1  synchronous, active-low reset.
- s_n  input  3  8088 status S2..S0; 3'b111 = passive.
- io_ch_rdy  input  1  expansion-bus ready; 0 requests extra waits.
- lock_n  input  1  CPU LOCK; 0 defers DMA grant.
- dma_req  input  1  hold request from 8237.
- rdy1  output  1  ready to 8284A; 0 inserts wait states.
- aen1  output  1  active-low enable for rdy1 at 8284A; 1 while DMA owns the bus.
- dma_ack  output  1  hold acknowledge to 8237.
- ch_timeout  output  1  one-cycle pulse when CH_TIMEOUT expires.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low: while reset==0 at a rising edge, all state is cleared.
- Reset values: state=IDLE, rdy1=1, aen1=0, dma_ack=0, ch_timeout=0, counters=0. A reset asserted mid-cycle or mid-DMA drops dma_ack and releases rdy1 on the next edge.
- Cycle start: a registered s_n that was 111 and is now non-111. Each cycle is decoded exactly once.
  - I/O read (001) or I/O write (010): I/O cycle.
  - Memory, interrupt-ack and halt codes: no forced waits.
- States:
  - IDLE: rdy1=1.
    - dma_req=1 with lock_n=1 and s_n==111 -> DMA_ARM. DMA takes priority over a cycle start seen in the same clock.
    - I/O cycle start with IO_WAITS>0 -> IO_WAIT with cnt=IO_WAITS.
    - Any cycle start with io_ch_rdy=0 -> CH_WAIT.
  - IO_WAIT: rdy1=0; cnt decrements each clock. At cnt==1 -> CH_WAIT if io_ch_rdy=0, else IDLE. rdy1 returns to 1 exactly IO_WAITS clocks after cycle start.
  - CH_WAIT: rdy1=0 while io_ch_rdy=0. On io_ch_rdy=1, rdy1=1 on the next edge and go to IDLE.
    - After CH_TIMEOUT clocks in CH_WAIT: pulse ch_timeout for 1 clock, force rdy1=1, go to IDLE.
    - The timeout counter is 8 bits, saturates, and is cleared on entry.
  - DMA_ARM: wait for the next cycle start; then rdy1=0, aen1=1 -> DMA_SYNC. If dma_req drops first -> IDLE with no outputs changed.
  - DMA_SYNC: count DMA_SYNC clocks, then dma_ack=1 -> DMA_ACTIVE.
  - DMA_ACTIVE: hold rdy1=0, aen1=1, dma_ack=1 while dma_req=1. On dma_req=0: dma_ack=0 -> DMA_RELEASE.
  - DMA_RELEASE: one clock with dma_ack=0, aen1=1, rdy1=0; then aen1=0, rdy1=1 -> IDLE.
- All outputs are registered; no combinational input-to-output paths.
- lock_n=0 only blocks entry to DMA_ARM. An already armed or active DMA is unaffected.
- IO_WAITS=0 disables forced I/O waits; io_ch_rdy is still honoured.

Decomposition:
- Shared package pc_bus_pkg holds:
  - the status encodings (ST_PASSIVE=3'b111, ST_IOR=3'b001, ST_IOW=3'b010, ST_INTA=3'b000, ST_HALT=3'b011);
  - the wait_state_gen state enum.
- One sub-module is natural: status_decode, which registers s_n and outputs cycle_start, is_io and is_passive.
- Counters stay inline.

Test Plan:
- Reset held 3 clocks mid-DMA_ACTIVE -> next edge dma_ack=0, aen1=0, rdy1=1; state IDLE.
- I/O read (s_n 111->001), io_ch_rdy=1, IO_WAITS=1 -> rdy1=0 for exactly 1 clock after cycle start; memory read (101) -> rdy1 never drops.
- I/O write with io_ch_rdy low 6 clocks -> rdy1 low for 6 clocks, high on the edge after io_ch_rdy rises, ch_timeout stays 0.
- io_ch_rdy stuck low, CH_TIMEOUT=255 -> ch_timeout pulses once 255 clocks into CH_WAIT; rdy1=1 the same edge.
- dma_req=1 while passive, lock_n=1 -> at next cycle start rdy1=0, aen1=1; dma_ack=1 exactly 2 clocks later; dma_req=0 -> dma_ack=0, then rdy1=1 and aen1=0 one clock later.
- dma_req=1 with lock_n=0 -> no grant; lock_n rises during passive status -> DMA_ARM entered on that clock.
